// File: rtl/exec_md_stage.sv
// Execute stage: forwarded operands, single-cycle ALU, iterative multiply/divide
// unit (one bit per cycle) and the EX/MEM output latch.
module exec_md_stage #(
    parameter int WIDTH    = 32,
    parameter int FWD_SRCS = 2
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic                               ihit,
    input  logic                               dhit,
    input  logic                               freeze,
    input  logic                               flush,
    input  logic                               in_valid,
    input  logic [3:0]                         op,
    input  logic                               alu_src,
    input  logic [WIDTH-1:0]                   port_a,
    input  logic [WIDTH-1:0]                   port_b,
    input  logic [WIDTH-1:0]                   imm,
    input  logic [$clog2(FWD_SRCS+1)-1:0]      fwd_sel_a,
    input  logic [$clog2(FWD_SRCS+1)-1:0]      fwd_sel_b,
    input  logic [FWD_SRCS*WIDTH-1:0]          fwd_data,
    input  logic                               mem_ren,
    input  logic                               mem_wen,
    input  logic                               reg_wen,
    input  logic                               halt,
    input  logic [4:0]                         rw,
    output logic                               stall_o,
    output logic                               ex_valid,
    output logic [WIDTH-1:0]                   ex_result,
    output logic [WIDTH-1:0]                   ex_store,
    output logic                               ex_zero,
    output logic                               ex_ren,
    output logic                               ex_wen,
    output logic                               ex_regwen,
    output logic                               ex_halt,
    output logic [4:0]                         ex_rw,
    output logic                               md_busy
);
    localparam int FS  = $clog2(FWD_SRCS + 1);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} md_state_t;

    // Select k (1..FWD_SRCS) picks slice k-1; anything else keeps the decode operand.
    function automatic logic [WIDTH-1:0] fwd_mux(input logic [FS-1:0] sel,
                                                 input logic [WIDTH-1:0] dflt,
                                                 input logic [FWD_SRCS*WIDTH-1:0] bus);
        fwd_mux = dflt;
        for (int k = 1; k <= FWD_SRCS; k++) begin
            fwd_mux = (int'(sel) == k) ? bus[(k-1)*WIDTH +: WIDTH] : fwd_mux;
        end
    endfunction

    md_state_t          state_r, state_s;
    logic [CW-1:0]      count_r, count_s;
    logic [WIDTH-1:0]   hi_r, hi_s, lo_r, lo_s, b_r, b_s;
    logic               is_div_r, is_div_s, sel_hi_r, sel_hi_s;

    logic [WIDTH-1:0]   opa_s, fwdb_s, opb_s, alu_res_s, res_s;
    logic [SHW-1:0]     shamt_s;
    logic               md_op_s, start_s, advance_s;
    logic [WIDTH:0]     mul_sum_s, div_sh_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_diff_s;

    assign opa_s   = fwd_mux(fwd_sel_a, port_a, fwd_data);
    assign fwdb_s  = fwd_mux(fwd_sel_b, port_b, fwd_data);
    assign opb_s   = alu_src ? imm : fwdb_s;
    assign shamt_s = opb_s[SHW-1:0];

    assign md_op_s   = (op >= 4'd10) && (op <= 4'd13);
    assign stall_o   = in_valid && md_op_s && (state_r != DONE);
    assign md_busy   = (state_r != IDLE);
    assign start_s   = in_valid && md_op_s && !(flush && ihit);
    assign advance_s = ihit && !flush && !freeze && !stall_o && !dhit;

    // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
    assign mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the remainder and subtract if it fits.
    assign div_sh_s   = {hi_r, lo_r[WIDTH-1]};
    assign div_ge_s   = (div_sh_s >= {1'b0, b_r});
    assign div_diff_s = div_sh_s[WIDTH-1:0] - b_r;

    // Single-cycle ALU
    always_comb begin
        alu_res_s = opa_s + opb_s;
        case (op)
            4'd1:    alu_res_s = opa_s - opb_s;
            4'd2:    alu_res_s = opa_s & opb_s;
            4'd3:    alu_res_s = opa_s | opb_s;
            4'd4:    alu_res_s = opa_s ^ opb_s;
            4'd5:    alu_res_s = ~(opa_s | opb_s);
            4'd6:    alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(opa_s) < $signed(opb_s))};
            4'd7:    alu_res_s = {{(WIDTH-1){1'b0}}, (opa_s < opb_s)};
            4'd8:    alu_res_s = opa_s << shamt_s;
            4'd9:    alu_res_s = opa_s >> shamt_s;
            default: alu_res_s = opa_s + opb_s;
        endcase
    end

    assign res_s = md_op_s ? (sel_hi_r ? hi_r : lo_r) : alu_res_s;

    // MD FSM next state and datapath step
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        b_s      = b_r;
        is_div_s = is_div_r;
        sel_hi_s = sel_hi_r;
        if (flush && ihit) begin
            state_s  = IDLE;
            count_s  = {CW{1'b0}};
            hi_s     = {WIDTH{1'b0}};
            lo_s     = {WIDTH{1'b0}};
            b_s      = {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_s  = RUN;
                        count_s  = CW'(WIDTH);
                        hi_s     = {WIDTH{1'b0}};
                        lo_s     = opa_s;
                        b_s      = opb_s;
                        is_div_s = op[2];
                        sel_hi_s = op[0];
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    count_s = count_r - CW'(1);
                    if (is_div_r) begin
                        hi_s = div_ge_s ? div_diff_s : div_sh_s[WIDTH-1:0];
                        lo_s = {lo_r[WIDTH-2:0], div_ge_s};
                    end else begin
                        hi_s = mul_sum_s[WIDTH:1];
                        lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
                    end
                    if (count_r == CW'(1)) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end
                DONE: begin
                    if (advance_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // MD state register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r  <= IDLE;
            count_r  <= {CW{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            sel_hi_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            b_r      <= b_s;
            is_div_r <= is_div_s;
            sel_hi_r <= sel_hi_s;
        end
    end

    // EX/MEM latch
    always_ff @(posedge CLK) begin
        if (!nRST || (flush && ihit)) begin
            ex_valid  <= 1'b0;
            ex_result <= {WIDTH{1'b0}};
            ex_store  <= {WIDTH{1'b0}};
            ex_zero   <= 1'b0;
            ex_ren    <= 1'b0;
            ex_wen    <= 1'b0;
            ex_regwen <= 1'b0;
            ex_halt   <= 1'b0;
            ex_rw     <= 5'd0;
        end else if (freeze || stall_o) begin
            ex_valid  <= ex_valid;
        end else if (dhit) begin
            ex_ren    <= 1'b0;
            ex_wen    <= 1'b0;
        end else if (ihit) begin
            ex_valid  <= in_valid;
            ex_result <= res_s;
            ex_store  <= fwdb_s;
            ex_zero   <= (res_s == {WIDTH{1'b0}});
            ex_ren    <= in_valid && mem_ren;
            ex_wen    <= in_valid && mem_wen;
            ex_regwen <= in_valid && reg_wen;
            ex_halt   <= in_valid && halt;
            ex_rw     <= rw;
        end else begin
            ex_valid  <= ex_valid;
        end
    end

endmodule

// File: doc/exec_md_stage.md
# exec_md_stage

Parametrised execute stage with N-source operand forwarding and an iterative multiply/divide unit. It sits between the decode and memory pipeline registers. Single-cycle ALU ops pass through as in the existing execute stage. Multiply/divide ops run for WIDTH cycles and hold the pipeline through a stall output. The stage owns the EX/MEM output latch.

## Interface
- WIDTH, 32, datapath width in bits (≥ 8, power of 2)
- FWD_SRCS, 2, number of forwarding sources; select width FS = $clog2(FWD_SRCS+1)

- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  reset, synchronous, active-low
- ihit  in  1  instruction fetch hit; pipeline advance enable
- dhit  in  1  data hit; clears latched mem_ren/mem_wen
- freeze  in  1  hazard-unit hold
- flush  in  1  squash; effective only together with ihit
- in_valid  in  1  decode register holds a live instruction
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 MULLO, 11 MULHU, 12 DIVU, 13 REMU; 14–15 behave as ADD
- alu_src  in  1  portb = imm (wins over forwarding)
- port_a, port_b, imm  in  WIDTH  decode operands
- fwd_sel_a, fwd_sel_b  in  FS  0 = decode operand, k = fwd_data slice k-1; values > FWD_SRCS select the decode operand
- fwd_data  in  FWD_SRCS*WIDTH  forwarding buses, source k at bits [k*WIDTH +: WIDTH]
- mem_ren, mem_wen, reg_wen, halt  in  1  control passthrough
- rw  in  5  destination register
- stall_o  out  1  execute busy; upstream must hold
- ex_valid  out  1  latched valid
- ex_result, ex_store  out  WIDTH  latched result; latched forwarded port_b (store data)
- ex_zero, ex_ren, ex_wen, ex_regwen, ex_halt  out  1  latched
- ex_rw  out  5  latched
- md_busy  out  1  FSM is not IDLE

## Operation
- Operand A = forwarded port_a. Operand B = imm if alu_src, else forwarded port_b. ex_store always takes forwarded port_b.
- ALU ops are combinational. Shift amount = B[$clog2(WIDTH)-1:0]. SLT is signed, SLTU is unsigned. ex_zero = (result == 0).
- MD ops use the FSM IDLE → RUN → DONE.
  - IDLE: when in_valid and op is an MD op and not (flush & ihit), capture A/B, set count = WIDTH and go to RUN.
  - RUN: one shift-add or restoring-divide step per cycle and count decrements. When count reaches 1 the step completes and the FSM goes to DONE.
  - DONE: hold the result. When the latch advances, go to IDLE.
- MULLO returns the low WIDTH bits of the 2·WIDTH product. MULHU returns the high WIDTH bits (unsigned).
- DIVU by 0 returns all-ones. REMU by 0 returns the dividend.
- stall_o = in_valid & md_op & (state != DONE), combinational.
- Latch priority, highest first:
  1. ~nRST: all outputs 0.
  2. flush & ihit: all outputs 0, FSM to IDLE (aborts a running op).
  3. freeze or stall_o: hold.
  4. dhit: hold, except ex_ren and ex_wen go to 0.
  5. ihit: load new values.
  6. Otherwise hold.
- A bubble (in_valid = 0) loads ex_valid = 0 and zeroes the control outputs.

## Timing
- Reset (synchronous, nRST low at a rising edge): every output 0, FSM IDLE, count 0. Reset mid-RUN aborts the op with no residue.
- ALU op: result visible on ex_* the cycle after the ihit edge. Latency 1.
- MD op, with operands captured at edge E0:
  - stall_o is high from the cycle before E0 through edge E0+WIDTH.
  - The FSM is in DONE after E0+WIDTH and stall_o drops.
  - The result latches at the first ihit edge from then on, giving a minimum latency of WIDTH+1 edges.
- A new MD op in the decode register immediately after DONE restarts from IDLE. There is no back-to-back overlap.
- If freeze is asserted while in DONE, the FSM stays in DONE until an edge where the latch advances.
- flush & ihit on the same edge as DONE→advance: flush wins and the result is discarded.
- Forwarding selects are sampled only at capture (IDLE). Changes during RUN are ignored.

## Test plan
- ADD with fwd_sel_a=2, fwd_data[1]=0x10, port_b=0x5, ihit -> ex_result=0x15, ex_zero=0, one cycle later.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32), ihit held high -> stall_o high for 33 cycles, then ex_result=0xFFFFFFFE. MULLO on the same operands -> 0x00000001.
- DIVU 100/7 -> 14 and REMU -> 2. DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5.
- flush & ihit at RUN cycle 10 of a DIVU -> md_busy=0 and all ex_* outputs 0 next cycle. The following ADD completes normally.
- ex_ren=1 latched, then dhit pulse with ihit=0 -> ex_ren=0, ex_result unchanged. nRST low mid-RUN -> all outputs 0 and FSM IDLE at that edge.
- Parameter sweep WIDTH=16, FWD_SRCS=3: fwd_sel=3 selects source 2, fwd_sel=0 selects port_a, MULLO 0x00FF×0x0101 -> 0xFFFF, stall length 17 cycles.
